// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: req/ack data bus between the MEM stage (master) and memory (slave).
interface mem_access_stage_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ack;
    modport master(output req, we, addr, be, wdata, input rdata, ack);
    modport slave(input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage and MEM/WB register performing loads/stores over a req/ack bus.
`ifndef MINIMIPS32_DEFS
`define MINIMIPS32_DEFS
`define ALUOP_BUS      7:0
`define REG_ADDR_BUS   4:0
`define REG_BUS        31:0
`define INST_ADDR_BUS  31:0
`define WORD_BUS       31:0
`define EXC_CODE_BUS   4:0
`define REG_NOP        5'b00000
`define PC_INIT        32'hBFC0_0000
`define EXC_NONE       5'h10
`define EXC_ADEL       5'h04
`define EXC_ADES       5'h05
`define EXC_DBE        5'h07
`define MINIMIPS32_LB  8'h90
`define MINIMIPS32_LBU 8'h91
`define MINIMIPS32_LH  8'h92
`define MINIMIPS32_LHU 8'h93
`define MINIMIPS32_LW  8'h94
`define MINIMIPS32_SB  8'h98
`define MINIMIPS32_SH  8'h99
`define MINIMIPS32_SW  8'h9A
`endif

module mem_access_stage #(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   cpu_clk_50M,
  input  logic                   cpu_rst,
  input  logic [`ALUOP_BUS]      mem_aluop,
  input  logic [`REG_ADDR_BUS]   mem_wa,
  input  logic                   mem_wreg,
  input  logic [`REG_BUS]        mem_wd,
  input  logic                   mem_mreg,
  input  logic [`REG_BUS]        mem_din,
  input  logic [`INST_ADDR_BUS]  mem_pc,
  input  logic [`EXC_CODE_BUS]   mem_exccode,
  input  logic                   flush,
  mem_access_stage_if.master     dbus,
  output logic                   stall_req_mem,
  output logic [`REG_ADDR_BUS]   wb_wa,
  output logic                   wb_wreg,
  output logic [`REG_BUS]        wb_wd,
  output logic [`INST_ADDR_BUS]  wb_pc,
  output logic [`EXC_CODE_BUS]   wb_exccode,
  output logic [`WORD_BUS]       wb_badvaddr
);
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
  state_t state, state_nx;
  logic [31:0] addr, shifted, load_data, cur_wdata, f_wdata;
  logic [3:0] cur_be, f_be;
  logic [ADDR_W-1:0] f_addr;
  logic [`EXC_CODE_BUS] exc;
  logic is_load, is_store, is_byte, is_half, is_signed, misal, up_exc, access, done, req, timeout, f_we;
  logic unused_mreg;
  assign addr = mem_wd;
  assign unused_mreg = mem_mreg;
  always_comb begin
    is_load = mem_aluop inside {`MINIMIPS32_LB, `MINIMIPS32_LBU, `MINIMIPS32_LH, `MINIMIPS32_LHU, `MINIMIPS32_LW};
    is_store = mem_aluop inside {`MINIMIPS32_SB, `MINIMIPS32_SH, `MINIMIPS32_SW};
    is_byte = mem_aluop inside {`MINIMIPS32_LB, `MINIMIPS32_LBU, `MINIMIPS32_SB};
    is_half = mem_aluop inside {`MINIMIPS32_LH, `MINIMIPS32_LHU, `MINIMIPS32_SH};
    is_signed = mem_aluop inside {`MINIMIPS32_LB, `MINIMIPS32_LH};
    misal = is_half ? addr[0] : (mem_aluop inside {`MINIMIPS32_LW, `MINIMIPS32_SW}) ? |addr[1:0] : 1'b0;
    up_exc = mem_exccode != `EXC_NONE;
    exc = up_exc ? mem_exccode : !misal ? `EXC_NONE : is_load ? `EXC_ADEL : `EXC_ADES;
    access = (is_load | is_store) & exc == `EXC_NONE & !flush & !cpu_rst;
    cur_be = is_byte ? 4'b0001 << addr[1:0] : is_half ? 4'b0011 << addr[1:0] : 4'b1111;
    cur_wdata = is_byte ? {4{mem_din[7:0]}} : is_half ? {2{mem_din[15:0]}} : mem_din;
    shifted = dbus.rdata >> {addr[1:0], 3'b000};
    load_data = is_byte ? {{24{is_signed & shifted[7]}}, shifted[7:0]}
              : is_half ? {{16{is_signed & shifted[15]}}, shifted[15:0]} : shifted;
  end
`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) < 8 ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge cpu_clk_50M)
    cnt <= (cpu_rst | state != WAIT) ? '0 : cnt + CNT_W'(1);
  assign timeout = state == WAIT & !dbus.ack & cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    req = 1'b1;
    stall_req_mem = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: begin
        req = access;
        stall_req_mem = access & !dbus.ack;
        if (stall_req_mem) state_nx = WAIT;
      end
      WAIT: begin
        done = dbus.ack | timeout;
        stall_req_mem = !done & !cpu_rst;
        if (dbus.ack) state_nx = IDLE;
        else if (flush | timeout) state_nx = DRAIN;
      end
      DRAIN: begin
        stall_req_mem = access;
        if (dbus.ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (cpu_rst) req = 1'b0;
  end
  always_ff @(posedge cpu_clk_50M)
    state <= cpu_rst ? IDLE : state_nx;
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      f_we <= 1'b0;
      f_addr <= '0;
      f_be <= '0;
      f_wdata <= '0;
    end else if (state == IDLE) begin
      f_we <= is_store;
      f_addr <= {addr[ADDR_W-1:2], 2'b00};
      f_be <= cur_be;
      f_wdata <= cur_wdata;
    end
  end
  assign dbus.req = req;
  assign dbus.we = state == IDLE ? is_store : f_we;
  assign dbus.addr = state == IDLE ? {addr[ADDR_W-1:2], 2'b00} : f_addr;
  assign dbus.be = state == IDLE ? cur_be : f_be;
  assign dbus.wdata = state == IDLE ? cur_wdata : f_wdata;
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst | flush | stall_req_mem) begin
      wb_wa <= `REG_NOP;
      wb_wreg <= 1'b0;
      wb_wd <= '0;
      wb_pc <= `PC_INIT;
      wb_exccode <= `EXC_NONE;
      wb_badvaddr <= '0;
    end else begin
      wb_wa <= mem_wa;
      wb_wreg <= mem_wreg & exc == `EXC_NONE & !is_store & !timeout;
      wb_wd <= (access & is_load & dbus.ack) ? load_data : mem_wd;
      wb_pc <= mem_pc;
      wb_exccode <= timeout ? `EXC_DBE : exc;
      wb_badvaddr <= (timeout | (misal & !up_exc)) ? addr : '0;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and randomized checks of mem_access_stage against a behavioural model.
module tb_mem_access_stage;
  localparam logic [7:0] LB = 8'h90, LBU = 8'h91, LH = 8'h92, LHU = 8'h93, LW = 8'h94;
  localparam logic [7:0] SB = 8'h98, SH = 8'h99, SW = 8'h9A, ADDU = 8'h18;
  localparam logic [4:0] NONE = 5'h10, ADEL = 5'h04, ADES = 5'h05, DBE = 5'h07, UPEXC = 5'h0C;
  localparam logic [31:0] PC_INIT = 32'hBFC0_0000;
  logic cpu_clk_50M = 1'b0;
  logic cpu_rst = 1'b1;
  logic [7:0] mem_aluop;
  logic [4:0] mem_wa, mem_exccode, wb_wa, wb_exccode;
  logic mem_wreg, mem_mreg, flush, stall_req_mem, wb_wreg;
  logic [31:0] mem_wd, mem_din, mem_pc, wb_wd, wb_pc, wb_badvaddr;
  logic [7:0] ops [9] = '{LB, LBU, LH, LHU, LW, SB, SH, SW, ADDU};
  int n_assert = 0;
  int n_fail = 0;

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  mem_access_stage_if bus();

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst), .mem_aluop(mem_aluop), .mem_wa(mem_wa),
    .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_mreg(mem_mreg), .mem_din(mem_din), .mem_pc(mem_pc),
    .mem_exccode(mem_exccode), .flush(flush), .dbus(bus), .stall_req_mem(stall_req_mem),
    .wb_wa(wb_wa), .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_pc(wb_pc), .wb_exccode(wb_exccode),
    .wb_badvaddr(wb_badvaddr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_wb(input logic [4:0] wa, input logic wreg, input logic [31:0] wd,
                          input logic [31:0] pc, input logic [4:0] exc, input logic [31:0] bad);
    chk("wb_wa", wb_wa, wa);
    chk("wb_wreg", wb_wreg, wreg);
    chk("wb_wd", wb_wd, wd);
    chk("wb_pc", wb_pc, pc);
    chk("wb_exccode", wb_exccode, exc);
    chk("wb_badvaddr", wb_badvaddr, bad);
  endtask

  task automatic bubble();
    check_wb(5'd0, 1'b0, 32'd0, PC_INIT, NONE, 32'd0);
  endtask

  function automatic int size_of(input logic [7:0] op);
    return (op == LB || op == LBU || op == SB) ? 1 : (op == LH || op == LHU || op == SH) ? 2 : 4;
  endfunction

  function automatic bit is_ld(input logic [7:0] op);
    return op == LB || op == LBU || op == LH || op == LHU || op == LW;
  endfunction

  function automatic bit is_st(input logic [7:0] op);
    return op == SB || op == SH || op == SW;
  endfunction

  function automatic logic [31:0] load_val(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rd);
    int sz;
    logic [31:0] v;
    sz = size_of(op);
    v = rd >> (8 * (a % 4));
    if (sz < 4) begin
      v = v % (32'h1 << (8 * sz));
      if ((op == LB || op == LH) && v >= (32'h1 << (8 * sz - 1))) v = v - (32'h1 << (8 * sz));
    end
    return v;
  endfunction

  task automatic step(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc,
                      input logic [4:0] ein, input int lat, input logic [31:0] rd, input logic wreg);
    int sz;
    bit misal, acc;
    logic [4:0] exc, wa;
    logic [31:0] exp_wd;
    sz = size_of(op);
    misal = (is_ld(op) || is_st(op)) && (a % sz != 0);
    exc = ein != NONE ? ein : misal ? (is_ld(op) ? ADEL : ADES) : NONE;
    acc = (is_ld(op) || is_st(op)) && exc == NONE;
    wa = 5'($urandom);
    exp_wd = (acc && is_ld(op)) ? load_val(op, a, rd) : a;
    mem_aluop = op; mem_wd = a; mem_din = d; mem_pc = pc; mem_exccode = ein;
    mem_wa = wa; mem_wreg = wreg; mem_mreg = is_ld(op); flush = 1'b0;
    for (int c = 0; c <= (acc ? lat : 0); c++) begin
      bus.ack = acc && c == lat;
      bus.rdata = (c == lat) ? rd : $urandom;
      #3;
      chk("req", bus.req, acc);
      chk("stall", stall_req_mem, acc && c < lat);
      if (acc) begin
        chk("addr", bus.addr, a & ~32'h3);
        chk("be", bus.be, ((32'h1 << sz) - 1) << (a % 4));
        chk("we", bus.we, is_st(op));
        chk("wdata", bus.wdata, sz == 4 ? d : sz == 2 ? d[15:0] * 32'h0001_0001 : d[7:0] * 32'h0101_0101);
      end
      @(posedge cpu_clk_50M); #1;
      if (acc && c < lat) bubble();
      else check_wb(wa, wreg && exc == NONE && !is_st(op), exp_wd, pc, exc, (ein == NONE && misal) ? a : 32'd0);
    end
    bus.ack = 1'b0;
  endtask

  initial begin
    mem_aluop = ADDU; mem_wa = 5'd0; mem_wreg = 1'b0; mem_wd = 32'd0; mem_mreg = 1'b0;
    mem_din = 32'd0; mem_pc = 32'd0; mem_exccode = NONE; flush = 1'b0;
    bus.ack = 1'b0; bus.rdata = 32'd0;
    repeat (2) @(posedge cpu_clk_50M);
    #1;
    bubble();
    chk("rst_req", bus.req, 1'b0);
    chk("rst_stall", stall_req_mem, 1'b0);
    cpu_rst = 1'b0;

    step(LW, 32'h0000_0104, 32'h0, 32'h100, NONE, 0, 32'hDEAD_BEEF, 1'b1);
    chk("lw_wd", wb_wd, 32'hDEAD_BEEF);
    chk("lw_wreg", wb_wreg, 1'b1);
    step(LB, 32'h0000_1003, 32'h0, 32'h104, NONE, 3, 32'h8011_2233, 1'b1);
    chk("lb_wd", wb_wd, 32'hFFFF_FF80);
    step(LBU, 32'h0000_1003, 32'h0, 32'h108, NONE, 3, 32'h8011_2233, 1'b1);
    chk("lbu_wd", wb_wd, 32'h0000_0080);
    step(SH, 32'h0000_2002, 32'h0000_ABCD, 32'h10C, NONE, 1, 32'h0, 1'b1);
    step(LH, 32'h0000_2002, 32'h0, 32'h110, NONE, 2, 32'h8001_7FFF, 1'b1);
    chk("lh_wd", wb_wd, 32'hFFFF_8001);
    step(LW, 32'h0000_3006, 32'h0, 32'h114, NONE, 0, 32'h0, 1'b1);
    chk("lw_adel", wb_exccode, ADEL);
    step(SW, 32'h0000_3006, 32'h0, 32'h118, NONE, 0, 32'h0, 1'b0);
    chk("sw_ades", wb_exccode, ADES);
    step(LW, 32'h0000_3006, 32'h0, 32'h11C, UPEXC, 0, 32'h0, 1'b1);
    step(ADDU, 32'h1234_5678, 32'h0, 32'h120, NONE, 0, 32'h0, 1'b1);

    mem_aluop = LW; mem_wd = 32'h0000_0300; mem_wreg = 1'b1; mem_exccode = NONE; mem_pc = 32'h200;
    bus.ack = 1'b0;
    #3; chk("fl_req0", bus.req, 1'b1); chk("fl_stall0", stall_req_mem, 1'b1);
    @(posedge cpu_clk_50M); #1; bubble();
    flush = 1'b1;
    #3; chk("fl_req1", bus.req, 1'b1);
    @(posedge cpu_clk_50M); #1; bubble();
    flush = 1'b0; mem_aluop = SW; mem_wd = 32'h0000_0404; mem_din = 32'h1122_3344; mem_wa = 5'd7; mem_pc = 32'h204;
    #3; chk("dr_req", bus.req, 1'b1); chk("dr_addr", bus.addr, 32'h300); chk("dr_we", bus.we, 1'b0);
    chk("dr_stall", stall_req_mem, 1'b1);
    @(posedge cpu_clk_50M); #1; bubble();
    bus.ack = 1'b1;
    #3; chk("dr_ack_addr", bus.addr, 32'h300); chk("dr_ack_stall", stall_req_mem, 1'b1);
    @(posedge cpu_clk_50M); #1; bubble();
    #3; chk("nx_req", bus.req, 1'b1); chk("nx_addr", bus.addr, 32'h404); chk("nx_we", bus.we, 1'b1);
    chk("nx_stall", stall_req_mem, 1'b0);
    @(posedge cpu_clk_50M); #1; check_wb(5'd7, 1'b0, 32'h404, 32'h204, NONE, 32'd0);
    bus.ack = 1'b0;

    mem_aluop = LW; mem_wd = 32'h0000_0500;
    @(posedge cpu_clk_50M); #1;
    cpu_rst = 1'b1;
    @(posedge cpu_clk_50M); #1;
    chk("mid_rst_req", bus.req, 1'b0); chk("mid_rst_stall", stall_req_mem, 1'b0); bubble();
    mem_aluop = ADDU; cpu_rst = 1'b0;
    #3; chk("post_rst_req", bus.req, 1'b0);
    @(posedge cpu_clk_50M); #1;

    for (int i = 0; i < 40; i++)
      step(ops[$urandom_range(0, 8)], $urandom, $urandom, $urandom,
           $urandom_range(0, 7) == 0 ? UPEXC : NONE, $urandom_range(0, 3), $urandom, 1'($urandom));

`ifdef MEM_TIMEOUT_EN
    mem_aluop = LW; mem_wd = 32'h0000_0600; mem_wa = 5'd9; mem_wreg = 1'b1; mem_pc = 32'h300;
    mem_exccode = NONE; bus.ack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #3; chk("to_req", bus.req, 1'b1); chk("to_stall", stall_req_mem, c < 4);
      @(posedge cpu_clk_50M); #1;
      if (c < 4) bubble();
      else check_wb(5'd9, 1'b0, 32'h600, 32'h300, DBE, 32'h600);
    end
    mem_aluop = ADDU; mem_wd = 32'h55; mem_pc = 32'h304;
    #3; chk("to_dr_req", bus.req, 1'b1); chk("to_dr_stall", stall_req_mem, 1'b0);
    @(posedge cpu_clk_50M); #1; check_wb(5'd9, 1'b1, 32'h55, 32'h304, NONE, 32'd0);
    bus.ack = 1'b1;
    #3; chk("to_late_ack_req", bus.req, 1'b1);
    @(posedge cpu_clk_50M); #1;
    bus.ack = 1'b0;
    #3; chk("to_idle_req", bus.req, 1'b0);
    @(posedge cpu_clk_50M); #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
